// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time base.
// Digit limits and o_count nibble positions live here.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAP,
    PAUSE
  } state_t;

  localparam logic [3:0] HUND_ONES_MAX = 4'd9;
  localparam logic [3:0] HUND_TENS_MAX = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX  = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX  = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX  = 4'd9;

  localparam int HO_LSB = 0;
  localparam int HT_LSB = 4;
  localparam int SO_LSB = 8;
  localparam int ST_LSB = 12;
  localparam int MO_LSB = 16;
  localparam int MT_LSB = 20;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit with a programmable wrap limit.
// carry is combinational so six digits ripple within one tick.
module bcd_digit_cnt #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch control: 100 Hz prescaler, MM:SS:hh BCD count,
// start/stop, lap-freeze and clear.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_stop,
  input  logic        i_lap,
  input  logic        i_clear,
  output logic [23:0] o_count,
  output logic        o_running,
  output logic        o_lap_active,
  output logic        o_rollover
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("stopwatch_bcd_counter: DIV must be >= 2");
  end

  state_t         state_q;
  state_t         state_d;
  logic [PW-1:0]  presc;
  logic [23:0]    live_cnt;
  logic [23:0]    lap_cnt;
  logic [6:0]     c;
  logic           counting;
  logic           tick;
  logic           take_lap;
  logic           do_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Higher-priority event wins only if it is legal in this state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_start_stop) state_d = RUN;
      end
      RUN: begin
        if (i_start_stop) state_d = PAUSE;
        else if (i_lap)   state_d = LAP;
      end
      LAP: begin
        if (i_start_stop) state_d = PAUSE;
        else if (i_lap)   state_d = RUN;
      end
      PAUSE: begin
        if (i_clear)           state_d = IDLE;
        else if (i_start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_running    = 1'b0;
    o_lap_active = 1'b0;
    unique case (state_q)
      RUN:     o_running = 1'b1;
      LAP: begin
        o_running    = 1'b1;
        o_lap_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc == PMAX);
  assign take_lap = (state_q == RUN) && (state_d == LAP);
  assign do_clr   = (state_q == PAUSE) && (state_d == IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst || do_clr) begin
      presc <= '0;
    end else if (counting) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  assign c[0] = tick;

  bcd_digit_cnt #(.MAX(HUND_ONES_MAX)) u_hund_ones (
    .clk(i_clk), .rst(i_rst), .clr(do_clr), .inc(c[0]),
    .digit(live_cnt[HO_LSB +: 4]), .carry(c[1])
  );

  bcd_digit_cnt #(.MAX(HUND_TENS_MAX)) u_hund_tens (
    .clk(i_clk), .rst(i_rst), .clr(do_clr), .inc(c[1]),
    .digit(live_cnt[HT_LSB +: 4]), .carry(c[2])
  );

  bcd_digit_cnt #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(i_clk), .rst(i_rst), .clr(do_clr), .inc(c[2]),
    .digit(live_cnt[SO_LSB +: 4]), .carry(c[3])
  );

  bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(i_clk), .rst(i_rst), .clr(do_clr), .inc(c[3]),
    .digit(live_cnt[ST_LSB +: 4]), .carry(c[4])
  );

  bcd_digit_cnt #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk(i_clk), .rst(i_rst), .clr(do_clr), .inc(c[4]),
    .digit(live_cnt[MO_LSB +: 4]), .carry(c[5])
  );

  bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(i_clk), .rst(i_rst), .clr(do_clr), .inc(c[5]),
    .digit(live_cnt[MT_LSB +: 4]), .carry(c[6])
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lap_cnt    <= '0;
      o_rollover <= 1'b0;
    end else begin
      if (take_lap) lap_cnt <= live_cnt;
      o_rollover <= c[6];
    end
  end

  assign o_count = (state_q == LAP) ? lap_cnt : live_cnt;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter at DIV = 10.
// Long runs are shortened by preloading the live digits.
module tb_stopwatch_bcd_counter;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss  = 1'b0;
  logic        lap = 1'b0;
  logic        clr = 1'b0;
  logic [23:0] count;
  logic        running;
  logic        lap_act;
  logic        roll;
  logic [23:0] fv = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start_stop(ss),
    .i_lap       (lap),
    .i_clear     (clr),
    .o_count     (count),
    .o_running   (running),
    .o_lap_active(lap_act),
    .o_rollover  (roll)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic l, input logic c);
    ss  = s;
    lap = l;
    clr = c;
    @(negedge clk);
    ss  = 1'b0;
    lap = 1'b0;
    clr = 1'b0;
  endtask

  // Preload live digits across one non-tick edge.
  task automatic set_live(input logic [23:0] v);
    fv = v;
    force dut.u_hund_ones.digit = fv[3:0];
    force dut.u_hund_tens.digit = fv[7:4];
    force dut.u_sec_ones.digit  = fv[11:8];
    force dut.u_sec_tens.digit  = fv[15:12];
    force dut.u_min_ones.digit  = fv[19:16];
    force dut.u_min_tens.digit  = fv[23:20];
    @(negedge clk);
    release dut.u_hund_ones.digit;
    release dut.u_hund_tens.digit;
    release dut.u_sec_ones.digit;
    release dut.u_sec_tens.digit;
    release dut.u_min_ones.digit;
    release dut.u_min_tens.digit;
  endtask

  initial begin
    cyc(2);
    check("rst_count", 32'(count), 32'h0);
    check("rst_run", 32'(running), 32'h0);
    check("rst_lap", 32'(lap_act), 32'h0);
    check("rst_roll", 32'(roll), 32'h0);
    rst = 1'b0;

    pulse(1, 0, 0);
    check("start_run", 32'(running), 32'h1);
    cyc(9);
    check("pre_tick", 32'(count), 32'h0);
    cyc(1);
    check("first_tick", 32'(count), 32'h000001);
    cyc(990);
    check("1000cyc", 32'(count), 32'h000100);

    pulse(0, 0, 1);
    check("clr_in_run", 32'(count), 32'h000100);
    check("clr_in_run_r", 32'(running), 32'h1);
    cyc(2);
    pulse(1, 0, 0);
    check("pause_run", 32'(running), 32'h0);
    cyc(100);
    check("pause_hold", 32'(count), 32'h000100);
    pulse(1, 0, 0);
    cyc(5);
    check("resume_5", 32'(count), 32'h000100);
    cyc(1);
    check("resume_6", 32'(count), 32'h000101);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    check("clear_cnt", 32'(count), 32'h0);
    check("clear_run", 32'(running), 32'h0);

    pulse(1, 0, 0);
    cyc(9);
    check("presc_clr_9", 32'(count), 32'h0);
    cyc(1);
    check("presc_clr_10", 32'(count), 32'h000001);

    cyc(1220);
    check("reach_123", 32'(count), 32'h000123);
    pulse(0, 1, 0);
    check("lap1_cnt", 32'(count), 32'h000123);
    check("lap1_act", 32'(lap_act), 32'h1);
    check("lap1_run", 32'(running), 32'h1);
    cyc(200);
    check("lap_frozen", 32'(count), 32'h000123);
    cyc(299);
    pulse(0, 1, 0);
    check("lap_exit_cnt", 32'(count), 32'h000173);
    check("lap_exit_act", 32'(lap_act), 32'h0);
    pulse(0, 1, 0);
    check("lap2_cnt", 32'(count), 32'h000173);
    check("lap2_act", 32'(lap_act), 32'h1);
    pulse(0, 1, 0);
    cyc(6);
    pulse(0, 1, 0);
    check("lap_on_tick", 32'(count), 32'h000173);
    pulse(1, 0, 0);
    check("lap_pause_cnt", 32'(count), 32'h000174);
    check("lap_pause_run", 32'(running), 32'h0);
    check("lap_pause_act", 32'(lap_act), 32'h0);
    pulse(1, 0, 1);
    check("clr_ss_cnt", 32'(count), 32'h0);
    check("clr_ss_run", 32'(running), 32'h0);

    pulse(1, 0, 0);
    cyc(2);
    set_live(24'h005999);
    cyc(6);
    check("pre_min", 32'(count), 32'h005999);
    cyc(1);
    check("carry_min", 32'(count), 32'h010000);
    cyc(2);
    set_live(24'h095999);
    cyc(7);
    check("carry_mt", 32'(count), 32'h100000);
    cyc(2);
    set_live(24'h995999);
    cyc(6);
    check("pre_wrap", 32'(count), 32'h995999);
    check("pre_wrap_r", 32'(roll), 32'h0);
    cyc(1);
    check("wrap_cnt", 32'(count), 32'h0);
    check("wrap_roll", 32'(roll), 32'h1);
    check("wrap_run", 32'(running), 32'h1);
    cyc(1);
    check("wrap_roll_off", 32'(roll), 32'h0);

    set_live(24'h012345);
    pulse(0, 1, 0);
    check("lap_pre_rst", 32'(count), 32'h012345);
    check("lap_pre_act", 32'(lap_act), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rstlap_cnt", 32'(count), 32'h0);
    check("rstlap_run", 32'(running), 32'h0);
    check("rstlap_act", 32'(lap_act), 32'h0);
    check("rstlap_roll", 32'(roll), 32'h0);
    rst = 1'b0;
    cyc(20);
    check("idle_hold", 32'(count), 32'h0);
    check("idle_run", 32'(running), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
